reset_seq: RTL and testbench

Parametrised system reset controller, successor to the single-source stretch reset.
- Combines an external asynchronous reset, a clock-good flag and NUM_SRC further reset requests (watchdog, software, debugger).
- Stretches the reset for a programmable count, then releases NUM_STAGES reset outputs in order with a fixed gap (e.g. memory/clock logic first, CPU last).
- Keeps a sticky reset-cause register that software reads after restart.

---
 rtl/reset_seq.sv | 139 +++++++++++++
 tb/tb_reset_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// System reset controller: merges async reset, clock-good and request sources, stretches,
// then releases NUM_STAGES reset outputs in order; keeps a sticky reset-cause register.
module reset_seq #(
   parameter int STRETCH     = 16777215,
   parameter int STAGE_GAP   = 16,
   parameter int NUM_STAGES  = 2,
   parameter int NUM_SRC     = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in_n,
   input  logic                  clk_ok,
   input  logic [NUM_SRC-1:0]    src_req,
   input  logic                  cause_clr,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic [NUM_STAGES-1:0] rst_out_n,
   output logic [NUM_SRC+1:0]    cause,
   output logic                  busy
);

   localparam int CMAX = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int KW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [CW-1:0] STRETCH_END = CW'(STRETCH - 1);
   localparam logic [CW-1:0] GAP_END     = CW'(STAGE_GAP - 1);
   localparam logic [KW-1:0] K_LAST      = KW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_STRETCH,
      ST_SEQ,
      ST_RUN
   } state_t;

   logic [SYNC_STAGES-1:0]              rel_sync;
   logic [SYNC_STAGES-1:0]              ok_sync;
   logic [SYNC_STAGES-1:0][NUM_SRC-1:0] req_sync;

   logic               rel_s;
   logic               ok_s;
   logic [NUM_SRC-1:0] req_s;
   logic               trigger;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [KW-1:0]           k, k_nxt;
   logic [NUM_STAGES-1:0]   rst_nxt;
   logic [NUM_SRC+1:0]      cause_nxt;

   // clk_ok sync resets high so a reset by rst_in_n is not also logged as a clock loss
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         rel_sync <= '0;
         ok_sync  <= '1;
         req_sync <= '0;
      end else begin
         rel_sync <= {rel_sync[SYNC_STAGES-2:0], 1'b1};
         ok_sync  <= {ok_sync[SYNC_STAGES-2:0], clk_ok};
         req_sync <= {req_sync[SYNC_STAGES-2:0], src_req};
      end
   end

   assign rel_s   = rel_sync[SYNC_STAGES-1];
   assign ok_s    = ok_sync[SYNC_STAGES-1];
   assign req_s   = req_sync[SYNC_STAGES-1];
   assign trigger = !rel_s || !ok_s || (|req_s);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      k_nxt     = k;
      rst_nxt   = rst_out;
      if (trigger) begin
         state_nxt = ST_HOLD;
         cnt_nxt   = '0;
         k_nxt     = '0;
         rst_nxt   = '1;
      end else begin
         case (state)
            ST_HOLD: begin
               state_nxt = ST_STRETCH;
               cnt_nxt   = '0;
               rst_nxt   = '1;
            end
            ST_STRETCH: begin
               if (cnt == STRETCH_END) begin
                  cnt_nxt    = '0;
                  k_nxt      = KW'(1);
                  rst_nxt[0] = 1'b0;
                  state_nxt  = (NUM_STAGES == 1) ? ST_RUN : ST_SEQ;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            ST_SEQ: begin
               if (cnt == GAP_END) begin
                  cnt_nxt    = '0;
                  rst_nxt[k] = 1'b0;
                  k_nxt      = k + KW'(1);
                  if (k == K_LAST) state_nxt = ST_RUN;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            default: rst_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state     <= ST_HOLD;
         cnt       <= '0;
         k         <= '0;
         rst_out   <= '1;
         rst_out_n <= '0;
         busy      <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         k         <= k_nxt;
         rst_out   <= rst_nxt;
         rst_out_n <= ~rst_nxt;
         busy      <= (state_nxt != ST_RUN);
      end
   end

   // A new cause on the same edge as a clear survives the clear
   always_comb begin
      cause_nxt = cause_clr ? '0 : cause;
      cause_nxt = cause_nxt | {req_s, !ok_s, 1'b0};
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) cause <= {{(NUM_SRC+1){1'b0}}, 1'b1};
      else           cause <= cause_nxt;
   end

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: directed scenarios plus random input traffic, checked every cycle
// against a model that tracks how long the synchronised trigger has stayed low.
module tb_reset_seq;

   localparam int STRETCH = 8;
   localparam int GAP     = 4;
   localparam int NS      = 2;
   localparam int NSRC    = 2;

   logic            clk_in    = 1'b0;
   logic            rst_in_n  = 1'b1;
   logic            clk_ok    = 1'b1;
   logic [NSRC-1:0] src_req   = '0;
   logic            cause_clr = 1'b0;
   logic [NS-1:0]   rst_out;
   logic [NS-1:0]   rst_out_n;
   logic [NSRC+1:0] cause;
   logic            busy;

   int n_checks = 0;
   int n_err    = 0;
   logic chk_en = 1'b0;

   reset_seq #(
      .STRETCH(STRETCH), .STAGE_GAP(GAP), .NUM_STAGES(NS), .NUM_SRC(NSRC), .SYNC_STAGES(2)
   ) dut (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .clk_ok(clk_ok), .src_req(src_req),
      .cause_clr(cause_clr), .rst_out(rst_out), .rst_out_n(rst_out_n), .cause(cause), .busy(busy)
   );

   always #10 clk_in = ~clk_in;

   // Model: q = number of consecutive edges at which the synchronised trigger was low.
   // Stage k is out of reset once q >= 1 + STRETCH + k*GAP.
   int              q;
   logic [NSRC+1:0] m_cause;
   logic [1:0]      rel_d, ok_d;
   logic [1:0][NSRC-1:0] req_d;

   always @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         q = 0; m_cause = 4'b0001; rel_d = '0; ok_d = '1; req_d = '0;
      end else begin
         if (cause_clr) m_cause = '0;
         m_cause = m_cause | {req_d[1], !ok_d[1], 1'b0};
         if (!rel_d[1] || !ok_d[1] || (req_d[1] != '0)) q = 0;
         else if (q < 1000) q = q + 1;
         rel_d = {rel_d[0], 1'b1};
         ok_d  = {ok_d[0], clk_ok};
         req_d = {req_d[0], src_req};
      end
   end

   function automatic logic [NS-1:0] exp_rst(int qq);
      logic [NS-1:0] r;
      for (int s = 0; s < NS; s++) r[s] = (qq >= 1 + STRETCH + s * GAP) ? 1'b0 : 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin
      if (chk_en) begin
         logic [NS-1:0] er;
         er = exp_rst(q);
         check("cycle", 32'({rst_out, rst_out_n, busy, cause}),
               32'({er, ~er, (q < 1 + STRETCH + (NS - 1) * GAP), m_cause}));
      end
   end

   task automatic count_until_fall(input int b, output int n);
      n = 0;
      do begin
         @(posedge clk_in); #1; n++;
      end while (rst_out[b] !== 1'b0 && n < 100);
   endtask

   task automatic wait_run(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(posedge clk_in); #1; n++;
      end
      check(name, 32'(busy), 32'(0));
   endtask

   task automatic pulse_req(input logic [NSRC-1:0] v);
      @(negedge clk_in); src_req = v;
      @(negedge clk_in); src_req = '0;
   endtask

   initial begin
      int n;
      #1 rst_in_n = 1'b0;
      #1 chk_en = 1'b1;

      // 1: power-up
      repeat (5) begin
         @(negedge clk_in); #1;
         check("por_hold", 32'(rst_out), 32'(2'b11));
      end
      @(negedge clk_in); rst_in_n = 1'b1;
      count_until_fall(0, n);
      check("por_rst0_latency", 32'(n), 32'(11));
      count_until_fall(1, n);
      check("por_rst1_gap", 32'(n), 32'(4));
      check("por_busy", 32'(busy), 32'(0));
      check("por_cause", 32'(cause), 32'(4'b0001));

      // 2: one-cycle src_req[1] pulse from RUN
      @(negedge clk_in); src_req = 2'b10;
      @(posedge clk_in); #1;
      @(negedge clk_in); src_req = '0;
      @(posedge clk_in); #1;
      check("req_edge2_run", 32'(rst_out), 32'(2'b00));
      @(posedge clk_in); #1;
      check("req_edge3_reset", 32'(rst_out), 32'(2'b11));
      check("req_cause", 32'(cause), 32'(4'b1001));
      wait_run("req_rerun");

      // 3: clk_ok lost during SEQ
      pulse_req(2'b01);
      n = 0;
      while (rst_out !== 2'b10 && n < 100) begin @(posedge clk_in); #1; n++; end
      check("seq_reached", 32'(rst_out), 32'(2'b10));
      @(negedge clk_in); clk_ok = 1'b0;
      repeat (3) @(posedge clk_in); #1;
      check("clk_loss_reassert", 32'(rst_out), 32'(2'b11));
      repeat (10) begin
         @(negedge clk_in);
         check("clk_loss_hold", 32'(rst_out), 32'(2'b11));
      end
      clk_ok = 1'b1;
      wait_run("clk_loss_rerun");
      check("clk_loss_cause", 32'(cause), 32'(4'b1111));

      // 4: src_req[0] held for 20 cycles
      @(negedge clk_in); src_req = 2'b01;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_in);
         if (i >= 3) check("held_req", 32'({rst_out, busy}), 32'(3'b111));
      end
      src_req = '0;
      count_until_fall(0, n);
      check("held_rst0_latency", 32'(n), 32'(11));
      count_until_fall(1, n);
      check("held_rst1_gap", 32'(n), 32'(4));

      // 5: cause_clr alone, then colliding with a new cause
      @(negedge clk_in); cause_clr = 1'b1;
      @(posedge clk_in); #1;
      check("clr_cause", 32'(cause), 32'(4'b0000));
      @(negedge clk_in); cause_clr = 1'b0; src_req = 2'b01;
      @(negedge clk_in); src_req = '0;
      @(negedge clk_in); cause_clr = 1'b1;
      @(posedge clk_in); #1;
      check("clr_vs_set", 32'(cause), 32'(4'b0100));
      @(negedge clk_in); cause_clr = 1'b0;
      wait_run("clr_rerun");

      // 6: rst_in_n mid-STRETCH and from RUN, observed without a clock edge
      pulse_req(2'b10);
      repeat (6) @(posedge clk_in);
      #5 rst_in_n = 1'b0;
      #1;
      check("async_stretch_rst", 32'({rst_out, rst_out_n, busy}), 32'(5'b11001));
      check("async_stretch_cause", 32'(cause), 32'(4'b0001));
      @(negedge clk_in); rst_in_n = 1'b1;
      wait_run("async_rerun1");
      @(posedge clk_in);
      #5 rst_in_n = 1'b0;
      #1;
      check("async_run_rst", 32'({rst_out, rst_out_n, busy}), 32'(5'b11001));
      @(negedge clk_in); rst_in_n = 1'b1;
      wait_run("async_rerun2");

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_in);
         clk_ok    = ($urandom_range(0, 199) != 0);
         src_req   = {($urandom_range(0, 149) == 0), ($urandom_range(0, 149) == 0)};
         cause_clr = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #3 rst_in_n = 1'b0;
            #4 rst_in_n = 1'b1;
         end
      end
      @(negedge clk_in);
      clk_ok = 1'b1; src_req = '0; cause_clr = 1'b0;
      wait_run("final_run");
      @(negedge clk_in);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
